// File: rtl/dual_cam_rd_splice_if.sv
// dual_cam_rd_splice_if: LCD read request, camera FIFO read ports and underflow status
interface dual_cam_rd_splice_if;
  logic        lcd_vs;
  logic        rd_en;
  logic [12:0] rd_h_pixel;
  logic [15:0] rd_data;
  logic        fifo0_rd_en;
  logic        fifo1_rd_en;
  logic [15:0] fifo0_rd_data;
  logic [15:0] fifo1_rd_data;
  logic        fifo0_empty;
  logic        fifo1_empty;
  logic        underflow;
  logic [7:0]  underflow_cnt;
  modport master (
    output lcd_vs, rd_en, rd_h_pixel, fifo0_rd_data, fifo1_rd_data, fifo0_empty, fifo1_empty,
    input  rd_data, fifo0_rd_en, fifo1_rd_en, underflow, underflow_cnt
  );
  modport slave (
    input  lcd_vs, rd_en, rd_h_pixel, fifo0_rd_data, fifo1_rd_data, fifo0_empty, fifo1_empty,
    output rd_data, fifo0_rd_en, fifo1_rd_en, underflow, underflow_cnt
  );
endinterface

// File: rtl/dual_cam_rd_splice.sv
// dual_cam_rd_splice: side-by-side splice of two camera FIFOs into one LCD pixel stream
module dual_cam_rd_splice #(
  parameter logic [15:0] FILL_COLOR    = 16'h0000,
  parameter bit          VS_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  dual_cam_rd_splice_if.slave bus
);
  logic        vs_q, sel_q, sub_q, frame, sel, sub, wrap;
  logic [12:0] line_w, x_cnt, w, x;
  logic [7:0]  cnt_base;
  // a frame start restarts the line at x = 0 with a freshly latched width, even mid-request
  always_comb begin
    frame = VS_ACTIVE_LOW ? (vs_q & ~bus.lcd_vs) : (~vs_q & bus.lcd_vs);
    x = frame ? '0 : x_cnt;
    w = (frame || x_cnt == '0) ? bus.rd_h_pixel : line_w;
    sel = (w > 13'd1) && (x >= {1'b0, w[12:1]});
    sub = sel ? bus.fifo1_empty : bus.fifo0_empty;
    wrap = (w == '0) || (x == w - 13'd1);
    bus.fifo0_rd_en = bus.rd_en & ~sel & ~bus.fifo0_empty;
    bus.fifo1_rd_en = bus.rd_en & sel & ~bus.fifo1_empty;
    bus.rd_data = sub_q ? FILL_COLOR : sel_q ? bus.fifo1_rd_data : bus.fifo0_rd_data;
    cnt_base = frame ? '0 : bus.underflow_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q              <= VS_ACTIVE_LOW;
      line_w            <= '0;
      x_cnt             <= '0;
      sel_q             <= 1'b0;
      sub_q             <= 1'b1;
      bus.underflow     <= 1'b0;
      bus.underflow_cnt <= '0;
    end else begin
      vs_q <= bus.lcd_vs;
      if (frame || x_cnt == '0) line_w <= bus.rd_h_pixel;
      if (bus.rd_en) begin
        x_cnt <= wrap ? '0 : x + 13'd1;
        sel_q <= sel;
        sub_q <= sub;
      end else if (frame) begin
        x_cnt <= '0;
      end
      if (bus.rd_en && sub) begin
        bus.underflow     <= 1'b1;
        bus.underflow_cnt <= (cnt_base == 8'hFF) ? cnt_base : cnt_base + 8'd1;
      end else if (frame) begin
        bus.underflow     <= 1'b0;
        bus.underflow_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dual_cam_rd_splice.sv
// tb_dual_cam_rd_splice: scoreboard bench with queue-based FIFO models and a pixel-position reference model
module tb_dual_cam_rd_splice;
  localparam logic [15:0] FILL = 16'hF81F;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dual_cam_rd_splice_if dif();
  dual_cam_rd_splice #(.FILL_COLOR(FILL), .VS_ACTIVE_LOW(1'b1)) dut (.clk(clk), .rst(rst), .bus(dif));
  int checks = 0, errors = 0;
  logic [15:0] q0[$], q1[$], exp_q[$];
  logic [1:0]  pop_q[$];
  logic [15:0] exp_dat;
  logic [1:0]  exp_pop;
  bit force0 = 0, force1 = 0, muf = 0, mprev = 1, req_d = 0;
  int mx = 0, mw = 0, mcnt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // camera FIFOs: normal-mode read, data appears the cycle after the pop
  always @(posedge clk) begin
    if (dif.fifo0_rd_en && q0.size() > 0) dif.fifo0_rd_data <= q0.pop_front();
    if (dif.fifo1_rd_en && q1.size() > 0) dif.fifo1_rd_data <= q1.pop_front();
    req_d <= !rst && dif.rd_en;
  end
  always @(negedge clk) begin
    if (dif.rd_en) begin
      if (pop_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected actual=%0b required=none", {dif.fifo1_rd_en, dif.fifo0_rd_en});
      end else begin
        exp_pop = pop_q.pop_front();
        chk("pop", {dif.fifo1_rd_en, dif.fifo0_rd_en}, exp_pop);
      end
    end else begin
      chk("idle_pop", {dif.fifo1_rd_en, dif.fifo0_rd_en}, 2'b00);
    end
    if (req_d) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_unexpected actual=%0h required=none", dif.rd_data);
      end else begin
        exp_dat = exp_q.pop_front();
        chk("rd_data", dif.rd_data, exp_dat);
      end
    end
  end
  // reference: each request is pixel mx of a line whose width is captured at its first pixel
  task automatic step();
    bit frame, left, emp;
    int w;
    frame = mprev && !dif.lcd_vs;
    if (frame) begin mx = 0; mcnt = 0; muf = 0; end
    if (dif.rd_en) begin
      w = (mx == 0) ? int'(dif.rd_h_pixel) : mw;
      mw = w;
      left = (w < 2) || (mx < w / 2);
      emp = left ? dif.fifo0_empty : dif.fifo1_empty;
      exp_q.push_back(emp ? FILL : left ? q0[0] : q1[0]);
      pop_q.push_back(emp ? 2'b00 : left ? 2'b01 : 2'b10);
      if (emp) begin muf = 1; if (mcnt < 255) mcnt++; end
      mx = (w == 0 || mx == w - 1) ? 0 : mx + 1;
    end
    mprev = dif.lcd_vs;
  endtask
  task automatic cyc(input bit en, input bit vs);
    dif.rd_en = en;
    dif.lcd_vs = vs;
    dif.fifo0_empty = force0 || q0.size() == 0;
    dif.fifo1_empty = force1 || q1.size() == 0;
    step();
    @(posedge clk); #1;
    chk("underflow", dif.underflow, muf);
    chk("underflow_cnt", dif.underflow_cnt, mcnt);
  endtask
  task automatic do_reset();
    dif.rd_en = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mx = 0; mw = 0; mcnt = 0; muf = 0; mprev = 1;
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back(16'($urandom));
      q1.push_back(16'($urandom));
    end
  endtask
  int s0, s1;
  initial begin
    rst = 1;
    dif.lcd_vs = 1; dif.rd_en = 0; dif.rd_h_pixel = 0;
    dif.fifo0_empty = 1; dif.fifo1_empty = 1;
    dif.fifo0_rd_data = 0; dif.fifo1_rd_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_rd_data", dif.rd_data, FILL);
    chk("reset_underflow", dif.underflow, 0);
    chk("reset_cnt", dif.underflow_cnt, 0);
    chk("reset_pops", {dif.fifo1_rd_en, dif.fifo0_rd_en}, 0);
    // basic split of an 800-pixel line
    for (int i = 0; i < 500; i++) begin
      q0.push_back(16'h1000 + 16'(i));
      q1.push_back(16'h2000 + 16'(i));
    end
    dif.rd_h_pixel = 800;
    repeat (800) cyc(1, 1);
    cyc(0, 1);
    chk("split_pops0", q0.size(), 100);
    chk("split_pops1", q1.size(), 100);
    chk("split_uf", dif.underflow, 0);
    // odd width: 2 left + 3 right per line
    q0.delete(); q1.delete();
    fill(10);
    dif.rd_h_pixel = 5;
    repeat (10) cyc(1, 1);
    cyc(0, 1);
    chk("odd_pops0", q0.size(), 6);
    chk("odd_pops1", q1.size(), 4);
    // right-half underflow, then cleared by frame start
    fill(20);
    repeat (2) cyc(1, 1);
    force1 = 1;
    repeat (3) cyc(1, 1);
    force1 = 0;
    cyc(0, 1);
    chk("uf_set", dif.underflow, 1);
    chk("uf_cnt3", dif.underflow_cnt, 3);
    cyc(0, 0);
    chk("uf_clr", dif.underflow, 0);
    chk("uf_cnt_clr", dif.underflow_cnt, 0);
    cyc(0, 1);
    // saturation, then frame start colliding with a substituted request
    force0 = 1; force1 = 1;
    repeat (300) cyc(1, 1);
    chk("sat_cnt", dif.underflow_cnt, 255);
    dif.rd_h_pixel = 2;
    cyc(1, 0);
    chk("collide_cnt", dif.underflow_cnt, 1);
    force0 = 0; force1 = 0;
    s1 = q1.size();
    cyc(1, 0);
    cyc(0, 1);
    chk("collide_x1_right", s1 - q1.size(), 1);
    // reset mid-line restarts at x = 0 on camera 0
    dif.rd_h_pixel = 5;
    repeat (3) cyc(1, 1);
    do_reset();
    s0 = q0.size();
    cyc(1, 1);
    cyc(0, 1);
    chk("reset_first_left", s0 - q0.size(), 1);
    repeat (4) cyc(1, 1);
    // width change mid-line only affects the next line
    fill(1400);
    s0 = q0.size(); s1 = q1.size();
    dif.rd_h_pixel = 800;
    repeat (500) cyc(1, 1);
    dif.rd_h_pixel = 480;
    repeat (300) cyc(1, 1);
    chk("w800_left", s0 - q0.size(), 400);
    chk("w800_right", s1 - q1.size(), 400);
    repeat (480) cyc(1, 1);
    cyc(0, 1);
    chk("w480_left", s0 - q0.size(), 640);
    chk("w480_right", s1 - q1.size(), 640);
    // randomized traffic including tiny widths, empties and frame edges
    q0.delete(); q1.delete();
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 4 && $urandom_range(0, 3) != 0) q0.push_back(16'($urandom));
      if (q1.size() < 4 && $urandom_range(0, 3) != 0) q1.push_back(16'($urandom));
      force0 = $urandom_range(0, 9) == 0;
      force1 = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 40) == 0) dif.rd_h_pixel = 13'($urandom_range(0, 12));
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 49) == 0) ? ~dif.lcd_vs : dif.lcd_vs);
    end
    force0 = 0; force1 = 0;
    repeat (3) cyc(0, 1);
    chk("scoreboard_drained", exp_q.size() + pop_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
